obd_frame_tx: RTL
=================

// Module: obd_frame_tx
// PURPOSE
//  Reads the vehicle-state outputs (speed, rpm, fuel, temp, odometer, gear, ESS) and transmits them as a 13-byte telemetry frame.
//  Output is one UART line, 8N1, LSB first. Sits downstream of the vehicle physics block.
//  Each request is typically driven by tick_1sec. All fields are snapshotted on frame start, so a frame is self-consistent.
// PARAMETERS
//  CLKS_PER_BIT  434    clk cycles per UART bit (50 MHz / 115200); must be >= 2
//  FRAME_SOF     8'hA5  start-of-frame byte
// PORTS
//  clk           in   1   system clock, single clock domain
//  rst           in   1   synchronous, active-low reset
//  send_req      in   1   one-cycle request to send a frame
//  engine_on     in   1   engine state
//  ess_trigger   in   1   emergency-stop alarm level (may be a 1-cycle pulse)
//  gear_num      in   3   current gear 1..6
//  speed         in   8   km/h
//  rpm           in   14  engine rpm
//  fuel          in   8   fuel %
//  temp          in   8   coolant deg C
//  odometer_raw  in   32  metres
//  uart_tx       out  1   serial line, idles high
//  busy          out  1   high while a frame is on the line
//  frame_done    out  1   one-cycle pulse after last stop bit
//  seq_num       out  8   sequence number of the next frame to be sent
// BEHAVIOUR
//  Reset (rst=0 at a clk edge)
//   - uart_tx=1, busy=0, frame_done=0, seq_num=0; pending and ess_sticky cleared.
//   - Reset wins over every other input, including mid-frame: line returns high on the next edge and the frame is abandoned.
//  Frame layout (byte index: content)
//   - 0 FRAME_SOF | 1 seq_num | 2 FLAGS = {engine_on, ess, 3'b000, gear_num}
//   - 3 speed | 4 {2'b00, rpm[13:8]} | 5 rpm[7:0] | 6 fuel | 7 temp
//   - 8..11 odometer_raw, MSB first | 12 CHK = XOR of bytes 1..11 (SOF excluded)
//  FSM: IDLE -> START -> DATA(8 bits) -> STOP; byte_idx runs 0..12; every bit is held exactly CLKS_PER_BIT cycles
//   - IDLE: if send_req or pending, snapshot all inputs and seq_num into the frame buffer, clear pending, go to START.
//     uart_tx falls on the next cycle; busy=1 from that cycle.
//   - STOP end, byte_idx<12: byte_idx++ and go to START. No idle gap between bytes.
//   - STOP end, byte_idx==12: go to IDLE; in that first IDLE cycle frame_done=1, busy=0, seq_num++ (wraps 255->0).
//  Timing
//   - Frame length is exactly 130*CLKS_PER_BIT cycles, from first start-bit cycle to the end of the last stop bit.
//   - A request in the frame_done cycle is accepted immediately; its start bit follows in the next cycle.
//  Requests while busy
//   - send_req while busy sets pending (1-deep). Further requests while pending is set are dropped.
//   - The pending frame takes a fresh snapshot in the IDLE cycle after frame_done.
//  ESS capture
//   - ess_sticky sets on a rising edge of ess_trigger (edge detected against a registered copy).
//   - FLAGS bit6 = ess_trigger | ess_sticky at snapshot time; ess_sticky clears at snapshot.
//   - A rising edge coincident with the snapshot is carried by ess_trigger, and sticky still clears.
//  Mid-frame input changes have no effect on the frame in flight.
// TESTING (sim with CLKS_PER_BIT=4)
//  1. rst=0 for 3 cycles, then rst=1 -> uart_tx=1, busy=0, frame_done=0, seq_num=0; line stays high with no send_req.
//  2. speed=100, rpm=2500, fuel=80, temp=90, odo=32'h00012345, gear=4, engine_on=1, ess=0; pulse send_req
//     -> bytes A5 00 84 64 09 C4 50 5A 00 01 23 45 40; frame_done exactly 520 cycles after the first start-bit cycle; seq_num=1.
//  3. As test 2, but speed changes to 0 during byte 1 -> byte 3 still 0x64, CHK still 0x40.
//  4. Two send_req pulses during frame 0 -> exactly one extra frame, byte1=0x01, start bit one cycle after frame_done; then idle.
//  5. 1-cycle ess_trigger pulse mid-frame -> next frame FLAGS bit6=1; the frame after (ess low) has bit6=0.
//  6. rst=0 during byte 5 -> uart_tx=1 next edge, busy=0, seq_num=0; a pending request is cleared and no frame follows.

Source files
------------

// File: rtl/obd_frame_tx.sv
// obd_frame_tx: snapshots the vehicle-state inputs and sends them as a
// 13-byte telemetry frame on a single 8N1 UART line, LSB first.
//
// Frame: A5 | seq | flags | speed | rpm_hi | rpm_lo | fuel | temp |
//        odo[31:24] | odo[23:16] | odo[15:8] | odo[7:0] | XOR of bytes 1..11
//
// Ports
//   clk           system clock
//   rst           synchronous, active-low reset
//   send_req      one-cycle frame request (1-deep pending while busy)
//   engine_on     engine state, flags bit 7
//   ess_trigger   emergency-stop alarm level, latched on rising edge
//   gear_num      gear 1..6, flags bits 2:0
//   speed         km/h
//   rpm           engine rpm (14 bits)
//   fuel          fuel %
//   temp          coolant deg C
//   odometer_raw  metres, sent MSB first
//   uart_tx       serial line, idles high
//   busy          high while a frame is on the line
//   frame_done    one-cycle pulse after the last stop bit
//   seq_num       sequence number of the next frame to be sent
module obd_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  FRAME_SOF    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_req,
    input  logic        engine_on,
    input  logic        ess_trigger,
    input  logic [2:0]  gear_num,
    input  logic [7:0]  speed,
    input  logic [13:0] rpm,
    input  logic [7:0]  fuel,
    input  logic [7:0]  temp,
    input  logic [31:0] odometer_raw,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  seq_num
);

    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [3:0]    byte_idx, byte_idx_n;
    logic          bit_end, accept, frame_end;

    logic          pending, ess_q, ess_sticky, done_q;

    logic [7:0]    snap_seq, snap_flags, snap_speed, snap_fuel, snap_temp;
    logic [13:0]   snap_rpm;
    logic [31:0]   snap_odo;
    logic [7:0]    chk, cur_byte;

    assign chk = snap_seq ^ snap_flags ^ snap_speed
               ^ {2'b00, snap_rpm[13:8]} ^ snap_rpm[7:0]
               ^ snap_fuel ^ snap_temp
               ^ snap_odo[31:24] ^ snap_odo[23:16] ^ snap_odo[15:8] ^ snap_odo[7:0];

    always_comb begin
        case (byte_idx)
            4'd0:    cur_byte = FRAME_SOF;
            4'd1:    cur_byte = snap_seq;
            4'd2:    cur_byte = snap_flags;
            4'd3:    cur_byte = snap_speed;
            4'd4:    cur_byte = {2'b00, snap_rpm[13:8]};
            4'd5:    cur_byte = snap_rpm[7:0];
            4'd6:    cur_byte = snap_fuel;
            4'd7:    cur_byte = snap_temp;
            4'd8:    cur_byte = snap_odo[31:24];
            4'd9:    cur_byte = snap_odo[23:16];
            4'd10:   cur_byte = snap_odo[15:8];
            4'd11:   cur_byte = snap_odo[7:0];
            default: cur_byte = chk;
        endcase
    end

    // Next-state, bit timing and line outputs
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        accept     = 1'b0;
        frame_end  = 1'b0;
        uart_tx    = 1'b1;
        busy       = (state != IDLE);
        frame_done = done_q;
        bit_end    = (clk_cnt == BIT_LAST);
        clk_cnt_n  = bit_end ? '0 : clk_cnt + 1'b1;

        case (state)
            IDLE: begin
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                byte_idx_n = '0;
                if (send_req || pending) begin
                    accept  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                uart_tx = cur_byte[bit_idx];
                if (bit_end) begin
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == 4'd12) begin
                        frame_end = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        byte_idx_n = byte_idx + 4'd1;
                        state_n    = START;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            pending    <= 1'b0;
            ess_q      <= 1'b0;
            ess_sticky <= 1'b0;
            done_q     <= 1'b0;
            seq_num    <= '0;
            snap_seq   <= '0;
            snap_flags <= '0;
            snap_speed <= '0;
            snap_rpm   <= '0;
            snap_fuel  <= '0;
            snap_temp  <= '0;
            snap_odo   <= '0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            ess_q    <= ess_trigger;
            done_q   <= frame_end;

            // Incremented on the closing edge so a request accepted in the
            // frame_done cycle already snapshots the new number.
            if (frame_end)
                seq_num <= seq_num + 8'd1;

            if (accept) begin
                pending    <= 1'b0;
                snap_seq   <= seq_num;
                snap_flags <= {engine_on, ess_trigger | ess_sticky, 3'b000, gear_num};
                snap_speed <= speed;
                snap_rpm   <= rpm;
                snap_fuel  <= fuel;
                snap_temp  <= temp;
                snap_odo   <= odometer_raw;
            end else if (send_req) begin
                pending <= 1'b1;
            end

            // A rise coincident with the snapshot is carried by ess_trigger
            // itself, so clearing wins here.
            if (accept)
                ess_sticky <= 1'b0;
            else if (ess_trigger && !ess_q)
                ess_sticky <= 1'b1;
        end
    end

endmodule
